key_irq_servicer: RTL and testbench

- Hardware Avalon-MM master that services the 4-bit key PIO in place of the Nios ISR.
- After reset it programs the PIO interrupt mask. On each PIO irq it reads edge_capture, clears it, and queues a timestamped key event in a small FIFO.
- Sits between the key PIO slave port and a streaming consumer (game/control logic), so key handling needs no CPU.

---
 rtl/key_svc_pkg.sv | 8 +
 rtl/key_evt_fifo.sv | 37 +++
 rtl/key_irq_servicer.sv | 109 ++++++++++
 tb/tb_key_irq_servicer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_svc_pkg.sv
// key_svc_pkg: shared FSM state type, PIO register addresses and key width for the key irq servicer
package key_svc_pkg;
  typedef enum logic [2:0] {INIT, IDLE, RD, SAMPLE, CLR} state_t;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam int KEY_W = 4;
endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: first-word-fall-through sync FIFO (push/pop/din -> dout/full/empty/count); a push into a full FIFO is accepted when a pop happens in the same cycle
module key_evt_fifo #(
  parameter int W = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/key_irq_servicer.sv
// key_irq_servicer: Avalon-MM master servicing the key PIO (mask init, edge read/clear) and queuing timestamped key events to a valid/ready stream with sticky overflow and drop count
module key_irq_servicer
  import key_svc_pkg::*;
#(
  parameter logic [3:0] IRQ_MASK = 4'hF,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic [1:0]          pio_address,
  output logic                pio_chipselect,
  output logic                pio_write_n,
  output logic [31:0]         pio_writedata,
  input  logic [31:0]         pio_readdata,
  input  logic                pio_irq,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_keys,
  output logic [TS_WIDTH-1:0] evt_time,
  output logic                overflow,
  output logic [7:0]          drop_count
);
  state_t state;
  logic [TS_WIDTH-1:0] ts, ts_lat;
  logic [KEY_W-1:0] keys;
  logic push, pop, drop, full, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [TS_WIDTH+KEY_W-1:0] head;
  logic unused_rd;
  assign unused_rd = ^pio_readdata[31:KEY_W];
  assign pop = evt_ready & ~empty;
  assign push = (state == CLR) && (keys != '0);
  assign drop = push & full & ~pop;
  assign evt_valid = count != '0;
  assign {evt_time, evt_keys} = head;
  key_evt_fifo #(.W(TS_WIDTH + KEY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({ts_lat, keys}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT;
      pio_chipselect <= 1'b0;
      pio_write_n <= 1'b1;
      pio_address <= ADDR_DATA;
      pio_writedata <= '0;
      ts <= '0;
      ts_lat <= '0;
      keys <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        drop_count <= drop_count + {7'd0, drop_count != 8'hFF};
      end
      case (state)
        INIT:
          if (!pio_chipselect) begin
            pio_chipselect <= 1'b1;
            pio_write_n <= 1'b0;
            pio_address <= ADDR_MASK;
            pio_writedata <= {{(32-KEY_W){1'b0}}, IRQ_MASK};
          end else begin
            state <= IDLE;
            pio_chipselect <= 1'b0;
            pio_write_n <= 1'b1;
            pio_address <= ADDR_DATA;
            pio_writedata <= '0;
          end
        IDLE:
          if (pio_irq && enable) begin
            state <= RD;
            pio_chipselect <= 1'b1;
            pio_write_n <= 1'b1;
            pio_address <= ADDR_EDGE;
          end
        RD: begin
          state <= SAMPLE;
          pio_chipselect <= 1'b0;
          ts_lat <= ts;
        end
        SAMPLE: begin
          state <= CLR;
          keys <= pio_readdata[KEY_W-1:0] & IRQ_MASK;
          pio_chipselect <= 1'b1;
          pio_write_n <= 1'b0;
          pio_writedata <= '0;
        end
        CLR: begin
          state <= IDLE;
          pio_chipselect <= 1'b0;
          pio_write_n <= 1'b1;
          pio_address <= ADDR_DATA;
        end
        default: state <= INIT;
      endcase
    end
endmodule

// File: tb/tb_key_irq_servicer.sv
// tb_key_irq_servicer: scoreboard bench with a key PIO model driving key_irq_servicer
module tb_key_irq_servicer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic [1:0] pio_address;
  logic pio_chipselect, pio_write_n, pio_irq;
  logic [31:0] pio_writedata, pio_readdata;
  logic evt_valid, overflow;
  logic evt_ready = 1'b0;
  logic [3:0] evt_keys;
  logic [15:0] evt_time;
  logic [7:0] drop_count;
  logic [3:0] key_in = 4'h0;
  logic [3:0] key_d, edge_cap, irq_mask;
  logic [15:0] cyc;
  logic [19:0] sb [$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int p0;

  always #5 clk = ~clk;

  key_irq_servicer #(.IRQ_MASK(4'hF), .FIFO_DEPTH(4), .TS_WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pio_address(pio_address),
    .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata),
    .pio_irq(pio_irq),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_keys(evt_keys),
    .evt_time(evt_time),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always @(posedge clk or posedge reset)
    if (reset) begin
      key_d <= 4'h0;
      edge_cap <= 4'h0;
      irq_mask <= 4'h0;
      pio_readdata <= 32'h0;
      cyc <= 16'h0;
    end else begin
      cyc <= cyc + 16'h1;
      key_d <= key_in;
      pio_readdata <= {28'h0, (pio_chipselect && pio_address == 2'd3) ? edge_cap :
                              (pio_chipselect && pio_address == 2'd2) ? irq_mask : 4'h0};
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) irq_mask <= pio_writedata[3:0];
      edge_cap <= ((pio_chipselect && !pio_write_n && pio_address == 2'd3) ? 4'h0 : edge_cap) | (key_in & ~key_d);
    end
  assign pio_irq = |(edge_cap & irq_mask);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_bus(input string name, input logic cs, input logic wn, input logic [1:0] a);
    chk({name, "_cs"}, 32'(pio_chipselect), 32'(cs));
    chk({name, "_wn"}, 32'(pio_write_n), 32'(wn));
    chk({name, "_addr"}, 32'(pio_address), 32'(a));
  endtask

  task automatic pulse(input logic [3:0] k, input bit expect_evt);
    key_in = k;
    if (expect_evt) sb.push_back({cyc + 16'd2, k});
    step();
    key_in = 4'h0;
    step(7);
  endtask

  always @(negedge clk) begin : monitor
    logic [19:0] e;
    if (!reset && evt_valid && evt_ready) begin
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got keys=%0h time=%0h expected none", evt_keys, evt_time);
      end else begin
        e = sb.pop_front();
        chk("evt_keys", 32'(evt_keys), 32'(e[3:0]));
        chk("evt_time", 32'(evt_time), 32'(e[19:4]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk_bus("rst", 1'b0, 1'b1, 2'd0);
    chk("rst_wd", pio_writedata, 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    step();
    @(negedge clk);
    chk_bus("init", 1'b1, 1'b0, 2'd2);
    chk("init_wd", pio_writedata, 32'hF);
    step();
    @(negedge clk);
    chk_bus("idle", 1'b0, 1'b1, 2'd0);
    chk("irq_mask", 32'(irq_mask), 32'hF);

    evt_ready = 1'b1;
    key_in = 4'b0010;
    sb.push_back({cyc + 16'd2, 4'b0010});
    step();
    key_in = 4'h0;
    step();
    @(negedge clk);
    chk_bus("rd", 1'b1, 1'b1, 2'd3);
    step(2);
    @(negedge clk);
    chk_bus("clr", 1'b1, 1'b0, 2'd3);
    chk("clr_wd", pio_writedata, 32'h0);
    step();
    @(negedge clk);
    chk("t2_valid", 32'(evt_valid), 32'h1);
    chk("t2_edge_cap", 32'(edge_cap), 32'h0);
    step(3);

    enable = 1'b0;
    key_in = 4'b1000;
    step();
    key_in = 4'h0;
    step(6);
    @(negedge clk);
    chk("dis_valid", 32'(evt_valid), 32'h0);
    chk("dis_cs", 32'(pio_chipselect), 32'h0);
    chk("dis_irq", 32'(pio_irq), 32'h1);
    step();
    enable = 1'b1;
    sb.push_back({cyc + 16'd1, 4'b1000});
    step(8);

    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) pulse(4'b0001, i < 4);
    chk("t3_ovf", 32'(overflow), 32'h1);
    chk("t3_drop", 32'(drop_count), 32'h1);
    p0 = pops;
    evt_ready = 1'b1;
    step(8);
    chk("t3_drained", 32'(pops - p0), 32'd4);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_valid", 32'(evt_valid), 32'h0);

    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(4'b0001, 1'b1);
    key_in = 4'b0001;
    sb.push_back({cyc + 16'd2, 4'b0001});
    step();
    key_in = 4'h0;
    step(3);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    step(4);
    chk("t4_drop", 32'(drop_count), 32'h1);
    p0 = pops;
    evt_ready = 1'b1;
    step(8);
    chk("t4_drained", 32'(pops - p0), 32'd4);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    p0 = pops;
    key_in = 4'b1001;
    sb.push_back({cyc + 16'd2, 4'b1001});
    step();
    key_in = 4'h0;
    step(2);
    key_in = 4'b0100;
    step();
    key_in = 4'h0;
    step(6);
    chk("t5_pops", 32'(pops - p0), 32'd1);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    chk("t5_edge_cap", 32'(edge_cap), 32'h0);
    chk("t5_valid", 32'(evt_valid), 32'h0);

    evt_ready = 1'b0;
    pulse(4'b0001, 1'b1);
    pulse(4'b0010, 1'b1);
    key_in = 4'b0100;
    step();
    key_in = 4'h0;
    step(2);
    @(negedge clk);
    chk("t6_sample_addr", 32'(pio_address), 32'd3);
    chk("t6_pre_valid", 32'(evt_valid), 32'h1);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    chk("t6_valid", 32'(evt_valid), 32'h0);
    chk_bus("t6_rst", 1'b0, 1'b1, 2'd0);
    chk("t6_ovf", 32'(overflow), 32'h0);
    chk("t6_drop", 32'(drop_count), 32'h0);
    step(2);
    reset = 1'b0;
    step();
    @(negedge clk);
    chk_bus("t6_init", 1'b1, 1'b0, 2'd2);
    chk("t6_init_wd", pio_writedata, 32'hF);
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
